day_stream_sequencer: RTL and testbench
=======================================

# day_stream_sequencer

- Sequences one puzzle run through the `day` datapath.
- Pulls input characters from a byte source over a valid/ready handshake and presents one character per accepted beat.
- Owns the running-result accumulator: it drives `result_in` and captures `result_out`.
- Reports the final result, the character count and the 1-based index of the first character at which the result hit a target value. It sits between the input reader and `day`, replacing bench-side feedback of `result_out` to `result_in`.

## Interface
- `RESULT_W`, default 32: signed result width, shared with `day`.
- `IDX_W`, default 16: width of the character counter and hit index.
- `TARGET`, default -1: signed value whose first occurrence is recorded.
- `TERM_CHAR`, default 8'h0A: end-of-input character; 8'h00 also terminates.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins a run when sampled in IDLE or DONE.
- `src_valid`  in  1  source byte valid.
- `src_data`  in  8  source byte.
- `src_ready`  out  1  sequencer accepts `src_data` this cycle.
- `dp_char`  out  8  character to `day.input_char`.
- `dp_result_in`  out  RESULT_W  accumulator to `day.result_in`.
- `dp_result_out`  in  RESULT_W  `day.result_out`, combinational from `dp_char` and `dp_result_in`.
- `busy`  out  1  state is RUN.
- `done`  out  1  state is DONE.
- `result`  out  RESULT_W  accumulator value.
- `char_count`  out  IDX_W  non-terminator characters accepted.
- `hit_valid`  out  1  `TARGET` has been reached this run.
- `hit_idx`  out  IDX_W  1-based index of the first hit.
- `overflow`  out  1  counter saturated before a terminator arrived.

## Operation
- States are IDLE, RUN and DONE; reset enters IDLE.
- **IDLE**
  - `src_ready`=0.
  - On `start`: clear the accumulator, `char_count`, `hit_valid`, `hit_idx` and `overflow`, then go to RUN.
- **RUN**
  - `src_ready`=1. A beat is accepted when `src_valid` is also 1.
  - **Terminator beat** (`src_data` is `TERM_CHAR` or 8'h00):
    - It is consumed, not applied to the datapath.
    - Go to DONE.
  - **Data beat**:
    - Accumulator <= `dp_result_out`.
    - `char_count` += 1.
    - If `dp_result_out`==`TARGET` and `hit_valid`=0: set `hit_valid`, and `hit_idx` <= `char_count`+1.
  - **Saturation**: when a data beat makes `char_count` equal 2^IDX_W-1, set `overflow` and go to DONE. No further beats are accepted.
  - `start` is ignored.
- **DONE**
  - `src_ready`=0; all outputs hold.
  - `start` clears the run state as in IDLE and goes directly to RUN.
- **Datapath drive**
  - `dp_char` = `src_data` on a data beat, else 8'h00.
  - `dp_result_in` = accumulator, always.
  - The accumulator updates only on data beats, so the datapath output is ignored on every other cycle.
- **Arithmetic**
  - The accumulator is signed RESULT_W with no saturation; wrap-around is the datapath's concern.
  - The counter never wraps.
- **Reset mid-run**: everything clears asynchronously, the FSM returns to IDLE, and a beat in flight is dropped.

## Timing
- Reset values are 0 for every output, including `src_ready`, `dp_char`, `dp_result_in`, `busy` and `done`.
- `src_ready`, `busy` and `done` are decoded from registered state only, with no combinational path from `src_valid`.
- Start latency: `start` high at edge N gives `src_ready`=1 in cycle N+1.
- `result`, `char_count`, `hit_valid` and `hit_idx` reflect an accepted beat in the cycle after the accepting edge.
- `done` rises the cycle after the terminator, or the saturating beat, is accepted.
- Throughput is one character per cycle with `src_valid` held high. Bubbles on `src_valid` stall the sequencer without changing results.
- A single-cycle `start` suffices; holding `start` in DONE restarts the run every time DONE is reached.

## Structure
- Package `day_seq_pkg` holds:
  - the state enum `seq_state_e` (IDLE, RUN, DONE);
  - constants `TERM_NL`=8'h0A and `TERM_NUL`=8'h00.
- Sub-module `hit_tracker`:
  - Inputs: `clk`, `rst`, `clear`, `fire`, `value`, `index`; parameterised by `TARGET`.
  - Outputs: `hit_valid`, `hit_idx`.
  - Record-once behaviour.
- The FSM, counter and accumulator stay in the top level.
- The bench uses a stub `day` for the scenarios below:
  - '(' adds 1;
  - ')' subtracts 1;
  - any other character leaves the result unchanged.

## Test plan
- **Basic run**: "(()\n", `src_valid` continuous → `result`=1, `char_count`=3, `hit_valid`=0, `done`=1 one cycle after '\n' is accepted.
- **Target hit**: "())(\n" → `hit_valid`=1, `hit_idx`=3, final `result`=0, `char_count`=4.
- **Source bubbles**: "())(\n" with `src_valid` low on every other cycle → outputs identical to the target-hit case; the run takes about 2x the cycles.
- **Restart**:
  - `start` pulsed in RUN → no effect.
  - `start` pulsed in DONE → counters and hit state clear, then ")\n" gives `result`=-1, `hit_idx`=1.
- **Reset mid-run**: `rst` asserted after two accepted characters → all outputs 0 immediately, IDLE, `src_ready`=0 until the next `start`.
- **Saturation**: `IDX_W`=2, "((((" with no terminator → DONE after the 3rd character, `overflow`=1, `char_count`=3, `result`=3, 4th byte not accepted.

Source files
------------

// File: rtl/day_seq_pkg.sv
// Shared definitions for the day stream sequencer.
//   seq_state_e : sequencer FSM states (IDLE, RUN, DONE)
//   TERM_NL     : default end-of-input character (newline)
//   TERM_NUL    : NUL, which always terminates a run
package day_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam logic [7:0] TERM_NL  = 8'h0A;
  localparam logic [7:0] TERM_NUL = 8'h00;

endpackage

// File: rtl/hit_tracker.sv
// Records the first index at which a running value equals TARGET.
// Once a hit is recorded it holds until the next clear.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : start of a new run, drops any recorded hit
//   fire      : value/index are valid this cycle (data beat)
//   value     : candidate running value
//   index     : 1-based index to record if value hits TARGET
//   hit_valid : a hit has been recorded
//   hit_idx   : index of the first hit
module hit_tracker #(
  parameter int                         RESULT_W = 32,
  parameter int                         IDX_W    = 16,
  parameter logic signed [RESULT_W-1:0] TARGET   = '1   // all ones == -1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       fire,
  input  logic signed [RESULT_W-1:0] value,
  input  logic        [IDX_W-1:0]    index,
  output logic                       hit_valid,
  output logic        [IDX_W-1:0]    hit_idx
);

  logic             hit_valid_q, hit_valid_d;
  logic [IDX_W-1:0] hit_idx_q, hit_idx_d;

  always_comb begin
    hit_valid_d = hit_valid_q;
    hit_idx_d   = hit_idx_q;
    if (clear) begin
      hit_valid_d = 1'b0;
      hit_idx_d   = '0;
    end else if (fire && !hit_valid_q && (value == TARGET)) begin
      hit_valid_d = 1'b1;
      hit_idx_d   = index;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_valid_q <= 1'b0;
      hit_idx_q   <= '0;
    end else begin
      hit_valid_q <= hit_valid_d;
      hit_idx_q   <= hit_idx_d;
    end
  end

  assign hit_valid = hit_valid_q;
  assign hit_idx   = hit_idx_q;

endmodule

// File: rtl/day_stream_sequencer.sv
// Sequences one puzzle run: pulls bytes from a valid/ready source, feeds
// them to the combinational `day` datapath and keeps the running result.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : begin a run (honoured in IDLE or DONE only)
//   src_valid/data  : byte source; src_ready high while in RUN
//   dp_char         : character to the datapath (0 when no data beat)
//   dp_result_in    : accumulator to the datapath
//   dp_result_out   : datapath result for dp_char applied to dp_result_in
//   busy / done     : state is RUN / DONE
//   result          : accumulator value
//   char_count      : non-terminator characters accepted
//   hit_valid/idx   : first 1-based index where result == TARGET
//   overflow        : counter saturated before a terminator arrived
module day_stream_sequencer
  import day_seq_pkg::*;
#(
  parameter int                         RESULT_W  = 32,
  parameter int                         IDX_W     = 16,
  parameter logic signed [RESULT_W-1:0] TARGET    = '1,     // all ones == -1
  parameter logic        [7:0]          TERM_CHAR = TERM_NL
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       src_valid,
  input  logic        [7:0]          src_data,
  output logic                       src_ready,
  output logic        [7:0]          dp_char,
  output logic signed [RESULT_W-1:0] dp_result_in,
  input  logic signed [RESULT_W-1:0] dp_result_out,
  output logic                       busy,
  output logic                       done,
  output logic signed [RESULT_W-1:0] result,
  output logic        [IDX_W-1:0]    char_count,
  output logic                       hit_valid,
  output logic        [IDX_W-1:0]    hit_idx,
  output logic                       overflow
);

  seq_state_e                 state_q, state_d;
  logic signed [RESULT_W-1:0] acc_q, acc_d;
  logic        [IDX_W-1:0]    count_q, count_d;
  logic                       overflow_q, overflow_d;

  logic             accept;
  logic             is_term;
  logic             data_beat;
  logic             saturate;
  logic             clear;
  logic [IDX_W-1:0] count_inc;

  assign accept    = (state_q == RUN) && src_valid;
  assign is_term   = (src_data == TERM_CHAR) || (src_data == TERM_NUL);
  assign data_beat = accept && !is_term;
  assign count_inc = count_q + IDX_W'(1);
  // The beat that brings the counter to all ones is the last one taken,
  // so the counter can never wrap.
  assign saturate  = data_beat && (count_inc == {IDX_W{1'b1}});
  // start is ignored while a run is in progress.
  assign clear     = start && (state_q != RUN);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if ((accept && is_term) || saturate) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase

    if (clear) begin
      acc_d      = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (data_beat) begin
      acc_d   = dp_result_out;
      count_d = count_inc;
      if (saturate) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  hit_tracker #(
    .RESULT_W (RESULT_W),
    .IDX_W    (IDX_W),
    .TARGET   (TARGET)
  ) u_hit (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .fire      (data_beat),
    .value     (dp_result_out),
    .index     (count_inc),
    .hit_valid (hit_valid),
    .hit_idx   (hit_idx)
  );

  // Handshake and status come from registered state only.
  assign src_ready    = (state_q == RUN);
  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
  // Terminators and idle cycles present NUL so the datapath sees no character.
  assign dp_char      = data_beat ? src_data : 8'h00;
  assign dp_result_in = acc_q;
  assign result       = acc_q;
  assign char_count   = count_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_day_stream_sequencer.sv
module tb_day_stream_sequencer;

  typedef logic [7:0] bq_t[$];

  logic               clk, rst;
  // main instance (default widths)
  logic               start, src_valid, src_ready, busy, done, hit_valid, overflow;
  logic        [7:0]  src_data, dp_char;
  logic signed [31:0] dp_result_in, dp_result_out, result;
  logic        [15:0] char_count, hit_idx;
  // saturation instance (IDX_W = 2)
  logic               start_s, src_valid_s, src_ready_s, busy_s, done_s, hit_valid_s, overflow_s;
  logic        [7:0]  src_data_s, dp_char_s;
  logic signed [31:0] dp_result_in_s, dp_result_out_s, result_s;
  logic        [1:0]  char_count_s, hit_idx_s;

  int checks = 0;
  int errors = 0;

  // stub day: '(' +1, ')' -1, anything else unchanged
  function automatic logic signed [31:0] stub_day(input logic [7:0] ch, input logic signed [31:0] r);
    if (ch == 8'h28) return r + 32'sd1;
    if (ch == 8'h29) return r - 32'sd1;
    return r;
  endfunction

  assign dp_result_out   = stub_day(dp_char, dp_result_in);
  assign dp_result_out_s = stub_day(dp_char_s, dp_result_in_s);

  day_stream_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .dp_char(dp_char), .dp_result_in(dp_result_in),
    .dp_result_out(dp_result_out), .busy(busy), .done(done), .result(result),
    .char_count(char_count), .hit_valid(hit_valid), .hit_idx(hit_idx), .overflow(overflow)
  );

  day_stream_sequencer #(.IDX_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start_s), .src_valid(src_valid_s), .src_data(src_data_s),
    .src_ready(src_ready_s), .dp_char(dp_char_s), .dp_result_in(dp_result_in_s),
    .dp_result_out(dp_result_out_s), .busy(busy_s), .done(done_s), .result(result_s),
    .char_count(char_count_s), .hit_valid(hit_valid_s), .hit_idx(hit_idx_s), .overflow(overflow_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Reference: walk the string, stop at a terminator or when the counter
  // reaches 2^idx_w-1. exp_acc counts bytes consumed from the source.
  task automatic model_run(input bq_t q, input int idx_w, output int exp_res, output int exp_cnt,
                           output bit exp_hit, output int exp_idx, output bit exp_ovf, output int exp_acc);
    exp_res = 0; exp_cnt = 0; exp_hit = 0; exp_idx = 0; exp_ovf = 0; exp_acc = 0;
    for (int i = 0; i < q.size(); i++) begin
      exp_acc++;
      if (q[i] == 8'h0A || q[i] == 8'h00) break;
      if (q[i] == 8'h28) exp_res++;
      else if (q[i] == 8'h29) exp_res--;
      exp_cnt++;
      if (!exp_hit && exp_res == -1) begin exp_hit = 1; exp_idx = exp_cnt; end
      if (exp_cnt == (1 << idx_w) - 1) begin exp_ovf = 1; break; end
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: continuous valid, 1: valid every other cycle, 2: random bubbles
  task automatic run_stream(input bq_t q, input int mode, output int accepted, output int cycles);
    int i;
    bit vld, rdy;
    i = 0; accepted = 0; cycles = 0;
    while (i < q.size() && done !== 1'b1 && cycles < 200) begin
      case (mode)
        0:       vld = 1'b1;
        1:       vld = (cycles % 2) == 1;
        default: vld = ($urandom_range(0, 3) != 0);
      endcase
      src_valid = vld;
      src_data  = q[i];
      rdy = src_ready;
      @(posedge clk); #1;
      if (vld && rdy) begin i++; accepted++; end
      cycles++;
    end
    src_valid = 1'b0;
    src_data  = 8'h00;
    checks++;
    if (cycles >= 200) begin
      errors++;
      $display("FAIL run_timeout: accepted %0d of %0d bytes in %0d cycles", accepted, q.size(), cycles);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; src_valid = 0; src_data = 0;
    start_s = 0; src_valid_s = 0; src_data_s = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({src_ready, busy, done, hit_valid, overflow} !== 5'b0) begin errors++;
      $display("FAIL reset_flags: got %b want 00000", {src_ready, busy, done, hit_valid, overflow}); end
    checks++; if (result !== 0 || dp_result_in !== 0) begin errors++;
      $display("FAIL reset_result: got %0d/%0d want 0/0", result, dp_result_in); end
    checks++; if (char_count !== 0 || hit_idx !== 0 || dp_char !== 0) begin errors++;
      $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", char_count, hit_idx, dp_char); end
    checks++; if ({src_ready_s, busy_s, done_s, overflow_s} !== 4'b0 || char_count_s !== 0) begin errors++;
      $display("FAIL reset_sat_inst: got %b cnt %0d want 0000 cnt 0", {src_ready_s, busy_s, done_s, overflow_s}, char_count_s); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (src_ready !== 1'b0) begin errors++;
      $display("FAIL idle_ready: got %b want 0", src_ready); end
    $display("reset: outputs cleared, idle");
  endtask

  task automatic test_basic();
    int acc, cyc;
    do_start();
    checks++; if (src_ready !== 1'b1 || busy !== 1'b1) begin errors++;
      $display("FAIL start_latency: ready %b busy %b want 1 1", src_ready, busy); end
    run_stream(str2q("(()\n"), 0, acc, cyc);
    checks++; if (result !== 1) begin errors++; $display("FAIL basic_result: got %0d want 1", result); end
    checks++; if (char_count !== 3) begin errors++; $display("FAIL basic_count: got %0d want 3", char_count); end
    checks++; if (hit_valid !== 1'b0 || overflow !== 1'b0) begin errors++;
      $display("FAIL basic_flags: hit %b ovf %b want 0 0", hit_valid, overflow); end
    checks++; if (done !== 1'b1 || src_ready !== 1'b0) begin errors++;
      $display("FAIL basic_done: done %b ready %b want 1 0", done, src_ready); end
    checks++; if (acc !== 4 || cyc !== 4) begin errors++;
      $display("FAIL basic_throughput: accepted %0d cycles %0d want 4 4", acc, cyc); end
    $display("basic: result=%0d count=%0d hit=%b cycles=%0d", result, char_count, hit_valid, cyc);
  endtask

  task automatic test_target_hit(input int mode);
    int acc, cyc;
    do_start();
    run_stream(str2q("())(\n"), mode, acc, cyc);
    checks++; if (hit_valid !== 1'b1 || hit_idx !== 3) begin errors++;
      $display("FAIL hit_idx_m%0d: hit %b idx %0d want 1 3", mode, hit_valid, hit_idx); end
    checks++; if (result !== 0 || char_count !== 4) begin errors++;
      $display("FAIL hit_result_m%0d: result %0d count %0d want 0 4", mode, result, char_count); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL hit_done_m%0d: got %b want 1", mode, done); end
    if (mode == 1) begin
      checks++; if (cyc !== 10) begin errors++; $display("FAIL bubble_cycles: got %0d want 10", cyc); end
    end
    $display("target_hit mode %0d: result=%0d count=%0d idx=%0d cycles=%0d", mode, result, char_count, hit_idx, cyc);
  endtask

  task automatic test_restart();
    int acc, cyc;
    do_start();
    run_stream(str2q(")"), 0, acc, cyc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1 || char_count !== 1 || result !== -1 || hit_idx !== 1) begin errors++;
      $display("FAIL start_in_run: busy %b count %0d result %0d idx %0d want 1 1 -1 1", busy, char_count, result, hit_idx); end
    run_stream(str2q("(\n"), 0, acc, cyc);
    checks++; if (done !== 1'b1 || result !== 0 || char_count !== 2 || hit_idx !== 1) begin errors++;
      $display("FAIL run_after_start: done %b result %0d count %0d idx %0d want 1 0 2 1", done, result, char_count, hit_idx); end
    do_start();
    checks++; if (busy !== 1'b1 || char_count !== 0 || result !== 0 || hit_valid !== 1'b0 || hit_idx !== 0) begin errors++;
      $display("FAIL restart_clear: busy %b count %0d result %0d hit %b idx %0d want 1 0 0 0 0", busy, char_count, result, hit_valid, hit_idx); end
    run_stream(str2q(")\n"), 0, acc, cyc);
    checks++; if (result !== -1 || hit_valid !== 1'b1 || hit_idx !== 1 || done !== 1'b1) begin errors++;
      $display("FAIL restart_run: result %0d hit %b idx %0d done %b want -1 1 1 1", result, hit_valid, hit_idx, done); end
    $display("restart: result=%0d idx=%0d", result, hit_idx);
  endtask

  task automatic test_reset_mid_run();
    int acc, cyc;
    do_start();
    run_stream(str2q("(("), 0, acc, cyc);
    src_valid = 1'b1;
    src_data  = 8'h28;
    #2 rst = 1'b1;
    #1;
    checks++; if ({src_ready, busy, done, hit_valid, overflow} !== 5'b0 || result !== 0 || char_count !== 0 || dp_char !== 0) begin errors++;
      $display("FAIL async_reset: flags %b result %0d count %0d char %0d want 0", {src_ready, busy, done, hit_valid, overflow}, result, char_count, dp_char); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (src_ready !== 1'b0 || busy !== 1'b0 || char_count !== 0) begin errors++;
      $display("FAIL post_reset_idle: ready %b busy %b count %0d want 0 0 0", src_ready, busy, char_count); end
    src_valid = 1'b0;
    $display("reset_mid_run: idle, count=%0d", char_count);
  endtask

  task automatic test_saturation();
    int acc, done_at;
    acc = 0; done_at = -1;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bit rdy;
      src_valid_s = 1'b1;
      src_data_s  = 8'h28;
      rdy = src_ready_s;
      @(posedge clk); #1;
      if (rdy) acc++;
      if (done_s === 1'b1 && done_at < 0) done_at = c + 1;
    end
    src_valid_s = 1'b0;
    checks++; if (acc !== 3 || done_at !== 3) begin errors++;
      $display("FAIL sat_accept: accepted %0d done_at %0d want 3 3", acc, done_at); end
    checks++; if (overflow_s !== 1'b1 || char_count_s !== 3 || result_s !== 3) begin errors++;
      $display("FAIL sat_state: ovf %b count %0d result %0d want 1 3 3", overflow_s, char_count_s, result_s); end
    checks++; if (src_ready_s !== 1'b0 || hit_valid_s !== 1'b0) begin errors++;
      $display("FAIL sat_ready: ready %b hit %b want 0 0", src_ready_s, hit_valid_s); end
    $display("saturation: count=%0d result=%0d ovf=%b", char_count_s, result_s, overflow_s);
  endtask

  task automatic test_random(input int runs);
    for (int r = 0; r < runs; r++) begin
      bq_t q;
      int len, acc, cyc, e_res, e_cnt, e_idx, e_acc;
      bit e_hit, e_ovf;
      len = $urandom_range(0, 12);
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 2))
          0:       q.push_back(8'h28);
          1:       q.push_back(8'h29);
          default: q.push_back(8'h78);
        endcase
      end
      q.push_back(($urandom_range(0, 1) != 0) ? 8'h0A : 8'h00);
      model_run(q, 16, e_res, e_cnt, e_hit, e_idx, e_ovf, e_acc);
      do_start();
      run_stream(q, 2, acc, cyc);
      checks++; if (result !== e_res || char_count !== e_cnt) begin errors++;
        $display("FAIL rand%0d_result: result %0d count %0d want %0d %0d", r, result, char_count, e_res, e_cnt); end
      checks++; if (hit_valid !== e_hit || hit_idx !== e_idx) begin errors++;
        $display("FAIL rand%0d_hit: hit %b idx %0d want %b %0d", r, hit_valid, hit_idx, e_hit, e_idx); end
      checks++; if (done !== 1'b1 || overflow !== e_ovf || acc !== e_acc) begin errors++;
        $display("FAIL rand%0d_done: done %b ovf %b accepted %0d want 1 %b %0d", r, done, overflow, acc, e_ovf, e_acc); end
      $display("random %0d: len=%0d result=%0d count=%0d hit=%b idx=%0d cycles=%0d", r, len, result, char_count, hit_valid, hit_idx, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_target_hit(0);
    test_target_hit(1);
    test_restart();
    test_reset_mid_run();
    test_saturation();
    test_random(25);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
